// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with an internal baud counter, a 2-FF input
// synchronizer, a one-byte holding register and sticky error flags.
//
// Consumer handshake (data_valid / rd_en): data_valid=1 means data holds an
// unread byte. rd_en=1 while data_valid=1 consumes it at that clock edge.
// rd_en while data_valid=0 is ignored. The serial side cannot be stalled, so a
// byte that completes while the holder is full is dropped and flagged as
// overrun, unless rd_en frees the holder in that same cycle.
module uart_rx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       RSTn,
  input  logic       rxd,
  input  logic       rd_en,
  input  logic       err_clr,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy,
  output logic [2:0] state_dbg
);

  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam int CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

  if (CLKS_PER_BIT < 4) begin : g_bad_clks_per_bit
    $error("uart_rx: CLKS_PER_BIT must be 4 or more");
  end

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          sync1_q, rxd_s;
  logic          stop_ok, stop_bad;
  logic          ov_set;

  // Two-flop synchronizer; idles high so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (RSTn) begin
      sync1_q <= 1'b1;
      rxd_s   <= 1'b1;
    end else begin
      sync1_q <= rxd;
      rxd_s   <= sync1_q;
    end
  end

  // FSM, bit timer, bit index and shift register state.
  always_ff @(posedge clk) begin
    if (RSTn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  // Next-state logic: start is qualified at mid-bit, every later bit is
  // sampled one full bit period after the previous sample point.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    stop_ok  = 1'b0;
    stop_bad = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rxd_s) state_d = S_START;
      end
      S_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          bit_d = '0;
          // A line that is high again at mid-start was a glitch.
          state_d = rxd_s ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {rxd_s, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (rxd_s) begin
            stop_ok = 1'b1;
            state_d = S_IDLE;
          end else begin
            stop_bad = 1'b1;
            state_d  = S_BREAK;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_BREAK: begin
        // Hold off start detection until the line has returned high.
        if (rxd_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign ov_set = stop_ok && data_valid && !rd_en;

  // Holding register and sticky flags; a set event beats err_clr.
  always_ff @(posedge clk) begin
    if (RSTn) begin
      data       <= 8'h00;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (stop_ok && (!data_valid || rd_en)) begin
        data       <= shift_q;
        data_valid <= 1'b1;
      end else if (rd_en && data_valid && !stop_ok) begin
        data_valid <= 1'b0;
      end
      frame_err <= stop_bad | (frame_err & ~err_clr);
      overrun   <= ov_set   | (overrun   & ~err_clr);
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: drives 8N1 frames into uart_rx and compares its outputs each
// cycle against a frame-level model of the receiver's consumer-side rules.
module tb_uart_rx;

  localparam int C    = 16;
  localparam int HALF = C / 2;
  // Clock edges from driving the start bit to seeing the accepted byte:
  // 2 synchronizer edges, 1 edge for the idle decision, then HALF + 9*C to
  // the stop-bit sample, whose result is registered on that same edge.
  localparam int LAT  = 3 + HALF + 9 * C;

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       RSTn, rxd, rd_en, err_clr;
  logic [7:0] data;
  logic       data_valid, frame_err, overrun, busy;
  logic [2:0] state_dbg;

  always #5 clk = ~clk;

  uart_rx #(.CLKS_PER_BIT(C)) dut (
    .clk(clk), .RSTn(RSTn), .rxd(rxd), .rd_en(rd_en), .err_clr(err_clr),
    .data(data), .data_valid(data_valid), .frame_err(frame_err),
    .overrun(overrun), .busy(busy), .state_dbg(state_dbg)
  );

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard / model ----------------
  int tests = 0;
  int fails = 0;
  int edge_n = 0;
  int start_edge = 0;
  int rise_edge = -1;
  logic prev_valid = 1'b0;
  bit rand_io = 1'b0;
  bit rd_at_accept = 1'b0;

  typedef struct {
    int         at;
    logic [7:0] b;
    logic       stop;
  } ev_t;
  ev_t ev_q[$];

  logic [7:0] m_data  = 8'h00;
  logic       m_valid = 1'b0;
  logic       m_fe    = 1'b0;
  logic       m_ov    = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", name, edge_n, act, exp);
    end
  endtask

  // Applies one clock edge of consumer-side behaviour using pre-edge inputs.
  task automatic model_step();
    ev_t  e;
    logic acc, bad, ov_set;
    logic [7:0] b;
    acc = 1'b0; bad = 1'b0; b = 8'h00;
    if (RSTn) begin
      m_data = 8'h00; m_valid = 1'b0; m_fe = 1'b0; m_ov = 1'b0;
      ev_q.delete();
      return;
    end
    if (ev_q.size() > 0 && ev_q[0].at == edge_n) begin
      e   = ev_q.pop_front();
      acc = e.stop;
      bad = !e.stop;
      b   = e.b;
    end
    ov_set = acc && m_valid && !rd_en;
    if (acc && (!m_valid || rd_en)) begin
      m_data  = b;
      m_valid = 1'b1;
    end else if (!acc && rd_en && m_valid) begin
      m_valid = 1'b0;
    end
    m_fe = bad    ? 1'b1 : (err_clr ? 1'b0 : m_fe);
    m_ov = ov_set ? 1'b1 : (err_clr ? 1'b0 : m_ov);
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    if (rand_io) begin
      rd_en   = ($urandom_range(0, 7) == 0);
      err_clr = ($urandom_range(0, 23) == 0);
    end
    if (rd_at_accept) rd_en = (ev_q.size() > 0 && ev_q[0].at == edge_n + 1);
    @(posedge clk);
    edge_n++;
    model_step();
    #1;
    if (!prev_valid && data_valid) rise_edge = edge_n;
    prev_valid = data_valid;
    check("data", {24'h0, data}, {24'h0, m_data});
    check("data_valid", {31'h0, data_valid}, {31'h0, m_valid});
    check("frame_err", {31'h0, frame_err}, {31'h0, m_fe});
    check("overrun", {31'h0, overrun}, {31'h0, m_ov});
  endtask

  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) tick();
  endtask

  // Drives the first nbits of {stop, b, start} onto the line, LSB first.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int nbits);
    logic [9:0] f;
    ev_t e;
    f          = {stop, b, 1'b0};
    start_edge = edge_n;
    rise_edge  = -1;
    e.at   = edge_n + LAT;
    e.b    = b;
    e.stop = stop;
    ev_q.push_back(e);
    for (int i = 0; i < nbits; i++) begin
      rxd = f[i];
      repeat (C) tick();
    end
  endtask

  task automatic pulse_rd();
    rd_en = 1'b1; tick(); rd_en = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       rd_pre;
    logic       clr_pre;
    logic [7:0] b;
    logic       stop;
    int         gap;
    logic [7:0] e_data;
    logic       e_valid;
    logic       e_fe;
    logic       e_ov;
  } vec_t;
  vec_t vecs[5];

  initial begin
    vecs[0] = '{1'b0, 1'b0, 8'h3C, 1'b1, 0, 8'h3C, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 8'hC3, 1'b1, 6, 8'h3C, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{1'b1, 1'b1, 8'h66, 1'b1, 6, 8'h66, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 8'h99, 1'b0, 6, 8'h66, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 8'h0F, 1'b1, 6, 8'h0F, 1'b1, 1'b0, 1'b0};

    RSTn = 1'b1; rxd = 1'b1; rd_en = 1'b0; err_clr = 1'b0;
    repeat (3) tick();
    check("rst_data", {24'h0, data}, 32'h00);
    check("rst_valid", {31'h0, data_valid}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    RSTn = 1'b0;
    idle(5);

    // Single byte, exact latency, then a read.
    send_frame(8'hA5, 1'b1, 10);
    idle(4);
    check("t1_latency", rise_edge - start_edge, LAT);
    check("t1_data", {24'h0, data}, 32'hA5);
    check("t1_fe", {31'h0, frame_err}, 32'h0);
    pulse_rd();
    check("t1_read_clears", {31'h0, data_valid}, 32'h0);
    check("t1_data_held", {24'h0, data}, 32'hA5);

    // Table: back-to-back, overrun, err_clr, frame error with data kept.
    for (int i = 0; i < 5; i++) begin
      if (vecs[i].rd_pre || vecs[i].clr_pre) begin
        rd_en = vecs[i].rd_pre; err_clr = vecs[i].clr_pre;
        tick();
        rd_en = 1'b0; err_clr = 1'b0;
      end
      send_frame(vecs[i].b, vecs[i].stop, 10);
      idle(vecs[i].gap);
      check($sformatf("vec%0d_data", i), {24'h0, data}, {24'h0, vecs[i].e_data});
      check($sformatf("vec%0d_valid", i), {31'h0, data_valid}, {31'h0, vecs[i].e_valid});
      check($sformatf("vec%0d_fe", i), {31'h0, frame_err}, {31'h0, vecs[i].e_fe});
      check($sformatf("vec%0d_ov", i), {31'h0, overrun}, {31'h0, vecs[i].e_ov});
    end

    // Bad stop bit followed by a held-low line.
    pulse_rd();
    send_frame(8'h55, 1'b0, 10);
    repeat (40) tick();
    check("t3_fe", {31'h0, frame_err}, 32'h1);
    check("t3_valid", {31'h0, data_valid}, 32'h0);
    check("t3_busy_in_break", {31'h0, busy}, 32'h1);
    begin
      int n;
      n = 0;
      rxd = 1'b1;
      while (busy && n < 3) begin tick(); n++; end
      check("t3_break_exit", {31'h0, busy}, 32'h0);
    end
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    check("t3_fe_cleared", {31'h0, frame_err}, 32'h0);

    // Short low glitch on an idle line.
    idle(10);
    begin
      logic saw_busy;
      saw_busy = 1'b0;
      rxd = 1'b0;
      for (int i = 0; i < 5; i++) begin tick(); if (busy) saw_busy = 1'b1; end
      rxd = 1'b1;
      for (int i = 0; i < 20; i++) begin tick(); if (busy) saw_busy = 1'b1; end
      check("t4_start_seen", {31'h0, saw_busy}, 32'h1);
      check("t4_busy", {31'h0, busy}, 32'h0);
      check("t4_valid", {31'h0, data_valid}, 32'h0);
      check("t4_flags", {30'h0, frame_err, overrun}, 32'h0);
    end

    // Read in exactly the accept cycle of a second byte.
    send_frame(8'h7E, 1'b1, 10);
    idle(2);
    rd_at_accept = 1'b1;
    send_frame(8'h81, 1'b1, 10);
    rd_at_accept = 1'b0;
    rd_en = 1'b0;
    idle(4);
    check("t5_data", {24'h0, data}, 32'h81);
    check("t5_valid", {31'h0, data_valid}, 32'h1);
    check("t5_ov", {31'h0, overrun}, 32'h0);
    pulse_rd();

    // Reset after data bit 3, then a clean frame.
    idle(4);
    send_frame(8'hAB, 1'b1, 5);
    RSTn = 1'b1;
    rxd  = 1'b1;
    repeat (3) tick();
    check("t6_rst_data", {24'h0, data}, 32'h00);
    check("t6_rst_valid", {31'h0, data_valid}, 32'h0);
    check("t6_rst_flags", {30'h0, frame_err, overrun}, 32'h0);
    check("t6_rst_busy", {31'h0, busy}, 32'h0);
    RSTn = 1'b0;
    idle(4);
    send_frame(8'hF0, 1'b1, 10);
    idle(4);
    check("t6_data", {24'h0, data}, 32'hF0);
    check("t6_valid", {31'h0, data_valid}, 32'h1);
    check("t6_flags", {30'h0, frame_err, overrun}, 32'h0);

    // Random frames, gaps, reads and clears against the model.
    rand_io = 1'b1;
    for (int i = 0; i < 30; i++) begin
      logic [7:0] b;
      logic       stop;
      b    = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 5) != 0);
      send_frame(b, stop, 10);
      idle(stop ? $urandom_range(0, 12) : $urandom_range(4, 12));
    end
    rand_io = 1'b0;
    rd_en = 1'b0; err_clr = 1'b0;
    idle(4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
